// File: rtl/cache_cmd_issuer_if.sv
// cache_cmd_issuer_if: upstream command handshake plus the cache-facing command bus
interface cache_cmd_issuer_if;
    logic        cmd_in_valid;
    logic        cmd_in_ready;
    logic [3:0]  cmd_in_n;
    logic [31:0] cmd_in_addr;
    logic [31:0] address;
    logic [3:0]  n;
    logic        valid;
    modport master (output cmd_in_valid, cmd_in_n, cmd_in_addr, input cmd_in_ready, address, n, valid);
    modport slave  (input cmd_in_valid, cmd_in_n, cmd_in_addr, output cmd_in_ready, address, n, valid);
endinterface

// File: rtl/cache_cmd_issuer.sv
// cache_cmd_issuer: FIFO-buffered one-at-a-time cache command issuer; CACHE_CMD_ISSUER_DROP_ILLEGAL_EN drops illegal codes
module cache_cmd_issuer #(
    parameter int DEPTH   = 8,
    parameter int OPR_LAT = 10
) (
    input  logic               clk,
    input  logic               rst,
    cache_cmd_issuer_if.slave  bus,
    output logic               busy,
    output logic               empty,
    output logic [15:0]        issued_cntr,
    output logic [15:0]        drop_cntr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OPR_LAT);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
    state_t         state;
    logic [35:0]    mem [DEPTH];
    logic [35:0]    head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [CW-1:0]  cnt;
    logic           full, acc, wr, pop;
    assign full             = count == (AW+1)'(DEPTH);
    assign empty            = count == '0;
    assign bus.cmd_in_ready = !full && !rst;
    assign acc              = bus.cmd_in_valid && bus.cmd_in_ready;
    assign pop              = state == IDLE && !empty;
    assign head             = mem[rd_ptr];
`ifdef CACHE_CMD_ISSUER_DROP_ILLEGAL_EN
    logic legal;
    assign legal = bus.cmd_in_n <= 4'd6 || bus.cmd_in_n == 4'd8 || bus.cmd_in_n == 4'd9;
    assign wr    = acc && legal;
    always_ff @(posedge clk) begin
        if (rst) drop_cntr <= '0;
        else if (acc && !legal) drop_cntr <= drop_cntr + 16'd1;
    end
`else
    assign wr        = acc;
    assign drop_cntr = '0;
`endif
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {bus.cmd_in_n, bus.cmd_in_addr};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
    // address/n stay held through BUSY so the cache can decode them combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.valid   <= 1'b0;
            bus.address <= '0;
            bus.n       <= '0;
            busy        <= 1'b0;
            cnt         <= '0;
            issued_cntr <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    bus.address <= head[31:0];
                    bus.n       <= head[35:32];
                    bus.valid   <= 1'b1;
                    busy        <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    bus.valid   <= 1'b0;
                    issued_cntr <= issued_cntr + 16'd1;
                    if (bus.n == 4'd8) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= CW'(OPR_LAT - 2);
                        state <= BUSY;
                    end
                end
                BUSY: if (cnt == '0) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_cmd_issuer.sv
// tb_cache_cmd_issuer: scoreboard bench for the cache command issuer
module tb_cache_cmd_issuer;
    localparam int DEPTH   = 8;
    localparam int OPR_LAT = 10;
`ifdef CACHE_CMD_ISSUER_DROP_ILLEGAL_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, empty;
    logic [15:0] issued_cntr, drop_cntr;
    cache_cmd_issuer_if bus();
    cache_cmd_issuer #(.DEPTH(DEPTH), .OPR_LAT(OPR_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .empty(empty),
        .issued_cntr(issued_cntr), .drop_cntr(drop_cntr)
    );
    always #5 clk = ~clk;
    int          checks = 0, failures = 0, cyc = 0;
    int          n_iss = 0, n_drop = 0, bcnt = 0, last_acc = 0;
    logic [35:0] exp_q[$];
    int          vt[$];
    logic        prev_v = 1'b0, prev_n8 = 1'b0;
    logic [31:0] cur_a = '0;
    logic [3:0]  cur_n = '0;
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask
    function automatic logic legal(input logic [3:0] c);
        return !DROP_EN || c <= 4'd6 || c == 4'd8 || c == 4'd9;
    endfunction
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_v  = 1'b0;
            prev_n8 = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (prev_n8) chk("no_busy_after_clr", busy, 0);
            if (bus.valid) begin
                chk("valid_gap", prev_v, 0);
                vt.push_back(cyc);
                n_iss++;
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("cmd", {bus.n, bus.address}, exp_q.pop_front());
                cur_a = bus.address;
                cur_n = bus.n;
            end else if (busy) begin
                chk("hold_addr", bus.address, cur_a);
                chk("hold_n", bus.n, cur_n);
            end
            prev_v  = bus.valid;
            prev_n8 = bus.valid && bus.n == 4'd8;
        end
    end
    task automatic push(input logic [3:0] c, input logic [31:0] a);
        int w = 0;
        @(negedge clk);
        bus.cmd_in_valid = 1'b1;
        bus.cmd_in_n     = c;
        bus.cmd_in_addr  = a;
        while (!bus.cmd_in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) chk("push_timeout", bus.cmd_in_ready, 1);
        if (legal(c)) exp_q.push_back({c, a});
        else n_drop++;
        @(posedge clk);
        #1;
        last_acc = cyc;
        bus.cmd_in_valid = 1'b0;
    endtask
    task automatic wait_idle(input int budget);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(!busy && empty) && w < budget);
        if (w >= budget) chk("idle_timeout", {busy, !empty}, 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog act=%0d exp=finish", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        int v0;
        bus.cmd_in_valid = 1'b0;
        bus.cmd_in_n     = '0;
        bus.cmd_in_addr  = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", bus.cmd_in_ready, 0);
        chk("rst_issued", issued_cntr, 0);
        chk("rst_drop", drop_cntr, 0);
        chk("rst_addr", bus.address, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_in_ready, 1);
        bcnt = 0;
        v0 = vt.size();
        push(4'd0, 32'h1234_5678);
        wait_idle(40);
        chk("single_strobes", vt.size() - v0, 1);
        if (vt.size() > v0) chk("single_latency", vt[v0], last_acc + 1);
        chk("single_busy_cycles", bcnt, OPR_LAT);
        chk("single_issued", issued_cntr, n_iss);
        v0 = vt.size();
        push(4'd1, 32'h0000_1000);
        push(4'd4, 32'h0000_2000);
        push(4'd0, 32'h0000_3000);
        wait_idle(100);
        chk("b2b_strobes", vt.size() - v0, 3);
        if (vt.size() == v0 + 3) begin
            chk("b2b_gap1", vt[v0+1] - vt[v0], OPR_LAT + 1);
            chk("b2b_gap2", vt[v0+2] - vt[v0+1], OPR_LAT + 1);
        end
        chk("b2b_issued", issued_cntr, n_iss);
        v0 = vt.size();
        push(4'd8, 32'h0000_0008);
        push(4'd0, 32'h0000_0009);
        wait_idle(60);
        chk("clr_strobes", vt.size() - v0, 2);
        if (vt.size() == v0 + 2) chk("clr_gap", vt[v0+1] - vt[v0], 2);
        v0 = vt.size();
        push(4'd7, 32'h0000_0777);
        wait_idle(40);
        repeat (15) @(negedge clk);
        chk("illegal_strobes", vt.size() - v0, legal(4'd7) ? 1 : 0);
        chk("illegal_drop", drop_cntr, n_drop);
        chk("illegal_empty", empty, 1);
        chk("illegal_issued", issued_cntr, n_iss);
        begin
            int acc = 0, run = 0, w = 0;
            logic seen_full = 1'b0;
            v0 = vt.size();
            @(negedge clk);
            while (acc < 20 && w < 2000) begin
                bus.cmd_in_valid = 1'b1;
                bus.cmd_in_n     = 4'(acc % 7);
                bus.cmd_in_addr  = 32'hA000_0000 + acc;
                if (bus.cmd_in_ready) begin
                    if (seen_full) run++;
                    exp_q.push_back({bus.cmd_in_n, bus.cmd_in_addr});
                    acc++;
                end else if (!seen_full) begin
                    seen_full = 1'b1;
                    chk("full_after_pushes", acc, DEPTH + 1);
                end else if (run > 0) begin
                    chk("ready_pulse", run, 1);
                    run = 0;
                end
                @(negedge clk);
                w++;
            end
            bus.cmd_in_valid = 1'b0;
            chk("stream_accepted", acc, 20);
            chk("saw_full", seen_full, 1);
            wait_idle(400);
            chk("stream_strobes", vt.size() - v0, 20);
            chk("stream_sb_drained", exp_q.size(), 0);
            chk("stream_issued", issued_cntr, n_iss);
        end
        v0 = vt.size();
        push(4'd0, 32'hB000_0000);
        push(4'd1, 32'hB000_0001);
        push(4'd2, 32'hB000_0002);
        begin
            int w = 0;
            while (vt.size() == v0 && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("mid_first_strobe", vt.size() - v0, 1);
        end
        repeat (3) @(negedge clk);
        chk("mid_in_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_valid", bus.valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_empty", empty, 1);
        chk("mid_issued", issued_cntr, 0);
        chk("mid_addr", bus.address, 0);
        chk("mid_n", bus.n, 0);
        chk("mid_drop", drop_cntr, 0);
        rst = 1'b0;
        exp_q.delete();
        n_iss = 0;
        n_drop = 0;
        v0 = vt.size();
        repeat (30) @(negedge clk);
        chk("mid_no_strobes", vt.size() - v0, 0);
        chk("mid_issued_after", issued_cntr, n_iss);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
